// File: rtl/result_writer_pkg.sv
// ============================================================================
// Module      : result_writer_pkg
// Description : Shared types and constants for the ALU result writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_writer_pkg;

    localparam int WORDS_PER_GROUP   = 4;
    localparam int GROUPS_PER_MATRIX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One capture entry: all MU words of a group plus the matrix-last flag.
    function automatic int entry_width(input int mu_w);
        return WORDS_PER_GROUP * mu_w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_writer_if.sv
// ============================================================================
// Module      : result_writer_if
// Description : ALU result group bus and result RAM write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_writer_if #(
    parameter int ADDR_W = 4,
    parameter int MU_W   = 18,
    parameter int OUT_W  = 16
) ();
    logic              alu_en_i;
    logic              web_i;
    logic              done_i;
    logic [MU_W-1:0]   mu1_i;
    logic [MU_W-1:0]   mu2_i;
    logic [MU_W-1:0]   mu3_i;
    logic [MU_W-1:0]   mu4_i;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [OUT_W-1:0]  ram_din;

    modport master (
        output alu_en_i, web_i, done_i, mu1_i, mu2_i, mu3_i, mu4_i,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  alu_en_i, web_i, done_i, mu1_i, mu2_i, mu3_i, mu4_i,
        output ram_we, ram_addr, ram_din
    );
endinterface

`default_nettype wire

// File: rtl/result_writer_fifo.sv
// ============================================================================
// Module      : result_fifo
// Description : Generic synchronous FIFO; a push while full is accepted only
//               when a pop frees the slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [WIDTH-1:0]           i_din,
    output logic      [WIDTH-1:0]           o_dout,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/result_writer.sv
// ============================================================================
// Module      : result_writer
// Description : Buffers ALU MU1..MU4 result groups and serialises them into
//               the result RAM. Optional macro RESULT_WR_SAT_EN saturates
//               words instead of truncating and adds the sat_flag output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_writer
    import result_writer_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int MU_W       = 18,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    result_writer_if.slave bus,
    output logic           busy,
    output logic           wr_done,
`ifdef RESULT_WR_SAT_EN
    output logic           sat_flag,
`endif
    output logic           overflow
);
    localparam int ENTRY_W = entry_width(MU_W);
    localparam int IDX_W   = $clog2(WORDS_PER_GROUP);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_GROUP - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [OUT_W-1:0]   r_ram_din;
    logic               r_wr_done;
    logic               r_overflow;
    logic               w_we_nxt;
    logic               w_done_nxt;
    logic               w_cap;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [MU_W-1:0]    w_word;
    logic [OUT_W-1:0]   w_din;

    assign w_cap     = bus.web_i & bus.alu_en_i;
    assign w_entry   = {bus.mu1_i, bus.mu2_i, bus.mu3_i, bus.mu4_i,
                        bus.done_i & bus.alu_en_i};
    assign w_pop     = (r_state == ST_DRAIN) && (r_idx == LAST_IDX);
    assign w_push_ok = w_cap && (!w_full || w_pop);

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cap),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // MU1 sits in the most significant slot of the entry.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < WORDS_PER_GROUP; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_word = w_head[1 + (WORDS_PER_GROUP - 1 - k) * MU_W +: MU_W];
            end
        end
    end

`ifdef RESULT_WR_SAT_EN
    logic w_sat;
    logic r_sat_flag;
    assign w_sat    = |w_word[MU_W-1:OUT_W];
    assign w_din    = w_sat ? '1 : w_word[OUT_W-1:0];
    assign sat_flag = r_sat_flag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_we_nxt && w_sat) begin
            r_sat_flag <= 1'b1;
        end
    end
`else
    logic [MU_W-OUT_W-1:0] w_unused_hi;
    assign w_unused_hi = w_word[MU_W-1:OUT_W];
    assign w_din       = w_word[OUT_W-1:0];
`endif

    // Entering DRAIN on the capture edge itself keeps the first write one
    // cycle after capture; IDLE/DONE therefore also look at the push.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty || w_push_ok) begin
                    w_state_nxt = ST_DRAIN;
                    w_idx_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                w_we_nxt = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_idx_nxt = '0;
                    if (w_head[0]) begin
                        w_state_nxt = ST_DONE;
                    end else if ((w_count > CNT_W'(1)) || w_push_ok) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = (!w_empty || w_push_ok) ? ST_DRAIN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_wr_done  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ram_we  <= w_we_nxt;
            r_wr_done <= w_done_nxt;
            if (w_we_nxt) begin
                r_ram_din <= w_din;
            end
            // Address advances after each visible write; DONE wins the clear.
            if (r_state == ST_DONE) begin
                r_ram_addr <= '0;
            end else if (r_ram_we) begin
                r_ram_addr <= r_ram_addr + 1'b1;
            end
            if (w_cap && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
    assign wr_done      = r_wr_done;
    assign overflow     = r_overflow;
    assign busy         = (r_state != ST_IDLE) || !w_empty;
endmodule

`default_nettype wire

// File: tb/tb_result_writer.sv
// ============================================================================
// Module      : tb_result_writer
// Description : Directed self-checking bench for result_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_writer;
    import result_writer_pkg::*;

    localparam int ADDR_W = 4;
    localparam int MU_W   = 18;
    localparam int OUT_W  = 16;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic wr_done;
    logic overflow;
`ifdef RESULT_WR_SAT_EN
    logic sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic              seen_we;

    result_writer_if #(.ADDR_W(ADDR_W), .MU_W(MU_W), .OUT_W(OUT_W)) bus ();

    result_writer #(
        .ADDR_W     (ADDR_W),
        .MU_W       (MU_W),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .wr_done  (wr_done),
`ifdef RESULT_WR_SAT_EN
        .sat_flag (sat_flag),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][MU_W-1:0]  mu;   // index 0 = MU1
        logic [3:0][OUT_W-1:0] din;  // expected RAM words in write order
        logic                  sat;  // expected sat_flag after this group
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0][MU_W-1:0] mu, input logic web, input logic en,
                         input logic done);
        bus.mu1_i    = mu[0];
        bus.mu2_i    = mu[1];
        bus.mu3_i    = mu[2];
        bus.mu4_i    = mu[3];
        bus.web_i    = web;
        bus.alu_en_i = en;
        bus.done_i   = done;
    endtask

    task automatic expect_write(input string name, input logic [OUT_W-1:0] d);
        tick;
        check({name, "_we"},   32'(bus.ram_we),   32'd1);
        check({name, "_addr"}, 32'(bus.ram_addr), 32'(exp_addr));
        check({name, "_din"},  32'(bus.ram_din),  32'(d));
        check({name, "_wrd"},  32'(wr_done),      32'd0);
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic pulse_reset;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        exp_addr = '0;
    endtask

    logic [3:0][MU_W-1:0] mu_tmp;

    initial begin
        rst      = 1'b0;
        exp_addr = '0;
        drive('0, 1'b0, 1'b0, 1'b0);

        vecs[0].mu  = {18'd40, 18'd30, 18'd20, 18'd10};
        vecs[0].din = {16'd40, 16'd30, 16'd20, 16'd10};
        vecs[0].sat = 1'b0;
        vecs[1].mu  = {18'h3_FFFF, 18'h1_0000, 18'h0_FFFF, 18'h2_0005};
`ifdef RESULT_WR_SAT_EN
        vecs[1].din = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
        vecs[1].din = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0005};
`endif
        vecs[1].sat = 1'b1;
        vecs[2].mu  = {18'h0_ABCD, 18'h0_1234, 18'h0_8001, 18'h0_0000};
        vecs[2].din = {16'hABCD, 16'h1234, 16'h8001, 16'h0000};
        vecs[2].sat = 1'b1;

        // Reset state
        repeat (3) tick;
        check("rst_we",       32'(bus.ram_we),   32'd0);
        check("rst_addr",     32'(bus.ram_addr), 32'd0);
        check("rst_din",      32'(bus.ram_din),  32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_wr_done",  32'(wr_done),      32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
`ifdef RESULT_WR_SAT_EN
        check("rst_sat", 32'(sat_flag), 32'd0);
`endif
        rst = 1'b1;
        tick;

        // Table-driven single groups; address keeps counting across groups
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i].mu, 1'b1, 1'b1, 1'b0);
            tick;
            drive('0, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            for (int k = 0; k < 4; k++) begin
                expect_write($sformatf("vec%0d_w%0d", i, k), vecs[i].din[k]);
            end
            tick;
            check($sformatf("vec%0d_we_end", i),   32'(bus.ram_we), 32'd0);
            check($sformatf("vec%0d_busy_end", i), 32'(busy),       32'd0);
`ifdef RESULT_WR_SAT_EN
            check($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(vecs[i].sat));
`endif
        end

        // Full matrix at nominal timing
        pulse_reset;
        for (int g = 0; g < GROUPS_PER_MATRIX; g++) begin
            for (int k = 0; k < 4; k++) mu_tmp[k] = MU_W'(100 + g * 4 + k);
            drive(mu_tmp, 1'b1, 1'b1, g == GROUPS_PER_MATRIX - 1);
            tick;
            drive('0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                expect_write($sformatf("mat_g%0d_w%0d", g, k), OUT_W'(100 + g * 4 + k));
            end
            if (g != GROUPS_PER_MATRIX - 1) repeat (3) tick;
        end
        tick;
        check("mat_wr_done", 32'(wr_done),      32'd1);
        check("mat_addr0",   32'(bus.ram_addr), 32'd0);
        check("mat_we_off",  32'(bus.ram_we),   32'd0);
        tick;
        check("mat_wr_done_pulse", 32'(wr_done),  32'd0);
        check("mat_overflow",      32'(overflow), 32'd0);

        // web without alu_en, and done without web, are ignored
        mu_tmp = {18'd4, 18'd3, 18'd2, 18'd1};
        drive(mu_tmp, 1'b1, 1'b0, 1'b1);
        seen_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            check($sformatf("noen_busy%0d", c), 32'(busy), 32'd0);
            seen_we = seen_we | bus.ram_we;
        end
        drive(mu_tmp, 1'b0, 1'b1, 1'b1);
        repeat (3) begin
            tick;
            seen_we = seen_we | bus.ram_we;
        end
        drive('0, 1'b0, 1'b0, 1'b0);
        check("noen_we",      32'(seen_we), 32'd0);
        check("noen_wr_done", 32'(wr_done), 32'd0);

        // Three back-to-back captures: two buffered, third dropped
        pulse_reset;
        drive({18'h14, 18'h13, 18'h12, 18'h11}, 1'b1, 1'b1, 1'b0);
        tick;
        drive({18'h24, 18'h23, 18'h22, 18'h21}, 1'b1, 1'b1, 1'b0);
        expect_write("ovf_a0", 16'h11);
        drive({18'h34, 18'h33, 18'h32, 18'h31}, 1'b1, 1'b1, 1'b0);
        expect_write("ovf_a1", 16'h12);
        drive('0, 1'b0, 1'b0, 1'b0);
        expect_write("ovf_a2", 16'h13);
        expect_write("ovf_a3", 16'h14);
        expect_write("ovf_b0", 16'h21);
        expect_write("ovf_b1", 16'h22);
        expect_write("ovf_b2", 16'h23);
        expect_write("ovf_b3", 16'h24);
        tick;
        check("ovf_we_end", 32'(bus.ram_we), 32'd0);
        check("ovf_flag",   32'(overflow),   32'd1);
        seen_we = 1'b0;
        repeat (100) begin
            tick;
            seen_we = seen_we | bus.ram_we;
        end
        check("ovf_no_third", 32'(seen_we),  32'd0);
        check("ovf_sticky",   32'(overflow), 32'd1);
        check("ovf_busy",     32'(busy),     32'd0);

        // Reset during the second write of a group
        pulse_reset;
        drive({18'h44, 18'h43, 18'h42, 18'h41}, 1'b1, 1'b1, 1'b0);
        tick;
        drive('0, 1'b0, 1'b0, 1'b0);
        expect_write("rmid_w0", 16'h41);
        expect_write("rmid_w1", 16'h42);
        rst = 1'b0;
        tick;
        check("rmid_we",       32'(bus.ram_we),   32'd0);
        check("rmid_addr",     32'(bus.ram_addr), 32'd0);
        check("rmid_busy",     32'(busy),         32'd0);
        check("rmid_overflow", 32'(overflow),     32'd0);
        rst = 1'b1;
        seen_we = 1'b0;
        repeat (8) begin
            tick;
            seen_we = seen_we | bus.ram_we;
        end
        check("rmid_no_writes", 32'(seen_we), 32'd0);
        check("rmid_idle_busy", 32'(busy),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
